// File: rtl/multicycle_alu_if.sv
// -----------------------------------------------------------------------------
// multicycle_alu_if
//   Request/response bundle for multicycle_alu.
//
//   Request (master -> slave):
//     start    : request an operation, sampled on the rising clock edge
//     aluCnt   : 4-bit operation select
//     input1   : operand A
//     input2   : operand B (also the value shifted by SLL/SRL/SRA)
//     shamt    : shift amount
//   Response (slave -> master):
//     busy     : a multi-cycle operation (MULU/DIVU) is iterating
//     done     : one-cycle completion pulse
//     result   : primary result (low product, quotient)
//     result_hi: high product or remainder, 0 for single-cycle operations
//     zero     : result == 0 (never looks at result_hi)
//
//   WIDTH/SHW must match the parameters of the multicycle_alu instance.
// -----------------------------------------------------------------------------
interface multicycle_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             start;
  logic [3:0]       aluCnt;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shamt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;

  modport master (
    output start, aluCnt, input1, input2, shamt,
    input  busy, done, result, result_hi, zero
  );

  modport slave (
    input  start, aluCnt, input1, input2, shamt,
    output busy, done, result, result_hi, zero
  );

endinterface

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//   ALU with single-cycle logic/arithmetic/shift operations and two iterative
//   operations: unsigned multiply (shift-add) and unsigned divide (restoring),
//   each taking exactly WIDTH RUN cycles.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : multicycle_alu_if.slave (start/aluCnt/input1/input2/shamt in,
//             busy/done/result/result_hi/zero out)
//
//   Operation codes (aluCnt):
//     0000 AND   0001 OR    0010 ADD   0110 SUB   0111 SLT (signed)
//     1100 NOR   0011 SLL   0100 SRL   0101 SRA   (shifts act on input2)
//     1000 MULU  {result_hi, result} = input1 * input2
//     1001 DIVU  result = quotient, result_hi = remainder
//     others     result = 0, result_hi = 0
//
//   Timing (accept edge = T0): single-cycle ops and DIVU by zero raise done in
//   the cycle ending at T0+1; MULU/DIVU raise done in the cycle ending at
//   T0+WIDTH+1. A new start is accepted in IDLE or in the DONE cycle.
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_alu_if.slave  bus
);

  // Counter wide enough to hold WIDTH-1 (iteration index, counts down).
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  // Iteration registers shared by multiply and divide.
  //   MULU: acc_hi = partial product high half, acc_lo = multiplier being
  //         shifted out / product low half, opnd = multiplicand
  //   DIVU: acc_hi = partial remainder, acc_lo = dividend being shifted out /
  //         quotient being shifted in, opnd = divisor
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic             is_div_reg;
  logic [CW-1:0]    cnt_reg;

  // Architecturally visible outputs, written only on completion.
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;

  logic             accept;
  logic             op_multi;
  logic             last_iter;
  logic [SHW-1:0]   shamt_in;

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] nor_bits;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  assign shamt_in  = bus.shamt;
  assign last_iter = (cnt_reg == '0);

  assign bus.result    = result_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.zero      = zero_reg;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    // Divide by zero is resolved immediately, so only a real divide iterates.
    op_multi   = (bus.aluCnt == OP_MULU) ||
                 ((bus.aluCnt == OP_DIVU) && (bus.input2 != '0));
    bus.busy   = 1'b0;
    bus.done   = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = bus.start;
        if (bus.start) begin
          state_next = op_multi ? RUN : DONE;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The completion cycle can also take the next request.
        bus.done = 1'b1;
        accept   = bus.start;
        if (bus.start) begin
          state_next = op_multi ? RUN : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (evaluated on the live request, captured on accept)
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_bits[gi] = bus.input1[gi] & bus.input2[gi];
    assign or_bits[gi]  = bus.input1[gi] | bus.input2[gi];
    assign nor_bits[gi] = ~(bus.input1[gi] | bus.input2[gi]);
  end

  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    case (bus.aluCnt)
      OP_AND:  sc_lo = and_bits;
      OP_OR:   sc_lo = or_bits;
      OP_NOR:  sc_lo = nor_bits;
      OP_ADD:  sc_lo = bus.input1 + bus.input2;
      OP_SUB:  sc_lo = bus.input1 - bus.input2;
      OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}},
                        ($signed(bus.input1) < $signed(bus.input2))};
      OP_SLL:  sc_lo = bus.input2 << shamt_in;
      OP_SRL:  sc_lo = bus.input2 >> shamt_in;
      OP_SRA:  sc_lo = $unsigned($signed(bus.input2) >>> shamt_in);
      OP_DIVU: begin
        // Only reached on this path when the divisor is zero.
        sc_lo = '1;
        sc_hi = bus.input1;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath: one multiply or divide step per RUN cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift-add multiply: add the multiplicand when the current multiplier
    // LSB is set, then shift the {carry, acc_hi, acc_lo} chain right by one.
    mul_sum = {1'b0, acc_hi_reg} + {1'b0, opnd_reg};
    if (acc_lo_reg[0]) begin
      mul_hi_next = mul_sum[WIDTH:1];
      mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end else begin
      mul_hi_next = {1'b0, acc_hi_reg[WIDTH-1:1]};
      mul_lo_next = {acc_hi_reg[0], acc_lo_reg[WIDTH-1:1]};
    end

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the trial subtraction only if it did not go negative (MSB clear).
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_reg};
    if (!div_trial[WIDTH]) begin
      div_hi_next = div_trial[WIDTH-1:0];
      div_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_next = div_shift[WIDTH-1:0];
      div_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
    end

    it_hi = is_div_reg ? div_hi_next : mul_hi_next;
    it_lo = is_div_reg ? div_lo_next : mul_lo_next;
  end

  // ---------------------------------------------------------------------------
  // Operand capture, iteration and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      opnd_reg      <= '0;
      is_div_reg    <= 1'b0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b1;
    end else if (accept) begin
      if (op_multi) begin
        is_div_reg <= (bus.aluCnt == OP_DIVU);
        acc_hi_reg <= '0;
        cnt_reg    <= CW'(WIDTH - 1);
        if (bus.aluCnt == OP_DIVU) begin
          acc_lo_reg <= bus.input1;
          opnd_reg   <= bus.input2;
        end else begin
          acc_lo_reg <= bus.input2;
          opnd_reg   <= bus.input1;
        end
      end else begin
        result_reg    <= sc_lo;
        result_hi_reg <= sc_hi;
        zero_reg      <= (sc_lo == '0);
      end
    end else if (state_reg == RUN) begin
      acc_hi_reg <= it_hi;
      acc_lo_reg <= it_lo;
      cnt_reg    <= cnt_reg - CW'(1);
      if (last_iter) begin
        result_reg    <= it_lo;
        result_hi_reg <= it_hi;
        zero_reg      <= (it_lo == '0);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
//   Directed vectors with hand-computed expectations for multicycle_alu
//   (WIDTH = 32). The driver pushes the expected response of every accepted
//   request into a scoreboard queue; an independent monitor pops and compares
//   whenever done is high, including the cycle in which done must appear.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(WIDTH)) bus ();

  multicycle_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          busy_cnt = 0;
  logic [31:0] last_res = '0;
  logic [31:0] last_hi  = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: one line per completed transaction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {63'd0, bus.done}, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("txn %-12s result=%h result_hi=%h zero=%b cycle=%0d",
                   e.name, bus.result, bus.result_hi, bus.zero, cyc);
          chk({e.name, "_result"}, {32'd0, bus.result}, {32'd0, e.res});
          chk({e.name, "_result_hi"}, {32'd0, bus.result_hi}, {32'd0, e.hi});
          chk({e.name, "_zero"}, {63'd0, bus.zero}, {63'd0, (e.res == 32'd0)});
          chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Issue one request. done is expected high in the cycle ending at T0+lat.
  // With hold set, start stays high and the task returns right after the
  // state reaches DONE so the next call is accepted back-to-back.
  task automatic send(input string name, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] er,
                      input logic [31:0] eh, input int lat, input bit hold);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.aluCnt = op;
    bus.input1 = a;
    bus.input2 = b;
    bus.shamt  = sh;
    @(posedge clk);
    #1;
    e.name = name;
    e.res  = er;
    e.hi   = eh;
    e.cyc  = cyc + lat - 1;
    sb.push_back(e);
    last_res = er;
    last_hi  = eh;
    if (hold) begin
      repeat (lat - 1) @(posedge clk);
    end else begin
      // Operands were captured; disturbing them now must not matter.
      @(negedge clk);
      bus.start  = 1'b0;
      bus.aluCnt = 4'($urandom);
      bus.input1 = $urandom;
      bus.input2 = $urandom;
      bus.shamt  = 5'($urandom);
      drain();
    end
  endtask

  initial begin
    int b0;
    exp_t e;

    // Reset, with a start request that must be ignored.
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.aluCnt = OP_ADD;
    bus.input1 = 32'd1;
    bus.input2 = 32'd1;
    bus.shamt  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    chk("rst_result_hi", {32'd0, bus.result_hi}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd1);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(posedge clk);

    // Single-cycle operations.
    send("add_6_3",   OP_ADD, 32'd6, 32'd3, 5'd0, 32'd9, 32'd0, 1, 1'b0);
    send("sub_10_10", OP_SUB, 32'd10, 32'd10, 5'd0, 32'd0, 32'd0, 1, 1'b0);
    send("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 1, 1'b0);
    send("sll_4_2",   OP_SLL, 32'h0000_DEAD, 32'd4, 5'd2, 32'd16, 32'd0, 1, 1'b0);
    send("sra_msb_4", OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0, 1, 1'b0);
    send("srl_msb_4", OP_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 32'd0, 1, 1'b0);
    send("slt_m1_1",  OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1, 1'b0);
    send("slt_1_m1",  OP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0, 1, 1'b0);
    send("and",       OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 32'd0, 1, 1'b0);
    send("or",        OP_OR,  32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 32'd0, 1, 1'b0);
    send("nor_0_0",   OP_NOR, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    send("nor_full",  OP_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 5'd0, 32'd0, 32'd0, 1, 1'b0);
    send("undef_op",  OP_BAD, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'd0, 32'd0, 1, 1'b0);

    // Multiply: busy must be high for exactly 32 cycles.
    b0 = busy_cnt;
    send("mulu_ff_2", OP_MULU, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    chk("mulu_busy_cycles", 64'(busy_cnt - b0), 64'd32);
    send("mulu_ff_ff", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'hFFFF_FFFE, 33, 1'b0);
    send("mulu_hi_only", OP_MULU, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'd0, 32'd1, 33, 1'b0);

    // Divide 100/7 with an ADD start at T0+5 that must be ignored.
    send("add_before", OP_ADD, 32'd6, 32'd3, 5'd0, 32'd9, 32'd0, 1, 1'b0);
    b0 = busy_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.aluCnt = OP_DIVU;
    bus.input1 = 32'd100;
    bus.input2 = 32'd7;
    @(posedge clk);
    #1;
    e.name = "divu_100_7";
    e.res  = 32'd14;
    e.hi   = 32'd2;
    e.cyc  = cyc + 32;
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.input1 = $urandom;
    bus.input2 = $urandom;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.aluCnt = OP_ADD;
    bus.input1 = 32'd5;
    bus.input2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("divu_busy_mid", {63'd0, bus.busy}, 64'd1);
    chk("divu_hold_result", {32'd0, bus.result}, {32'd0, last_res});
    chk("divu_hold_result_hi", {32'd0, bus.result_hi}, {32'd0, last_hi});
    drain();
    chk("divu_busy_cycles", 64'(busy_cnt - b0), 64'd32);

    // Divide by zero completes at once and never raises busy.
    b0 = busy_cnt;
    send("divu_55_0", OP_DIVU, 32'd55, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd55, 1, 1'b0);
    chk("divu0_busy_cycles", 64'(busy_cnt - b0), 64'd0);
    send("divu_7_100", OP_DIVU, 32'd7, 32'd100, 5'd0, 32'd0, 32'd7, 33, 1'b0);
    send("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);

    // Back-to-back with start held high.
    send("b2b_add", OP_ADD,  32'd1, 32'd2, 5'd0, 32'd3, 32'd0, 1, 1'b1);
    send("b2b_sub", OP_SUB,  32'd5, 32'd3, 5'd0, 32'd2, 32'd0, 1, 1'b1);
    send("b2b_mul", OP_MULU, 32'd3, 32'd5, 5'd0, 32'd15, 32'd0, 33, 1'b1);
    send("b2b_and", OP_AND,  32'hC, 32'hA, 5'd0, 32'd8, 32'd0, 1, 1'b0);

    // Reset at T0+10 of a multiply: abort with no done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.aluCnt = OP_MULU;
    bus.input1 = 32'hFFFF_FFFF;
    bus.input2 = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_result", {32'd0, bus.result}, 64'd0);
    chk("abort_result_hi", {32'd0, bus.result_hi}, 64'd0);
    chk("abort_zero", {63'd0, bus.zero}, 64'd1);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    send("add_1_1", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 32'd0, 1, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; the block SHALL support any WIDTH from 4 to 64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), the shift-amount width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port start, input, 1 bit: request operation, sampled at rising edge.
REQ-007 Port aluCnt, input, 4 bits: operation select.
REQ-008 Port input1, input, WIDTH bits: operand A.
REQ-009 Port input2, input, WIDTH bits: operand B.
REQ-010 Port shamt, input, SHW bits: shift amount.
REQ-011 Port busy, output, 1 bit: multi-cycle operation in progress.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port result, output, WIDTH bits: primary result (low product, quotient).
REQ-014 Port result_hi, output, WIDTH bits: high product or remainder, otherwise 0.
REQ-015 Port zero, output, 1 bit: result == 0.

Function
REQ-016 Operations SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1/0); 1100 NOR; 0011 SLL input2 by shamt; 0100 SRL input2 by shamt; 0101 SRA input2 by shamt; 1000 MULU; 1001 DIVU.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; result_hi = 0 for every single-cycle operation.
REQ-018 An undefined aluCnt SHALL complete in 1 cycle with result = 0, result_hi = 0, zero = 1.
REQ-019 Operands, aluCnt and shamt SHALL be captured on the accept edge; later input changes SHALL have no effect.
REQ-020 start SHALL be accepted only when busy = 0; start while busy = 1 SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, RUN, DONE.
REQ-022 IDLE + accepted single-cycle op -> DONE; IDLE + accepted MULU/DIVU -> RUN.
REQ-023 RUN SHALL iterate exactly WIDTH cycles (shift-add for MULU, restoring for DIVU), then go to DONE.
REQ-024 DONE SHALL last one cycle: done = 1, then -> IDLE, or accept a new start in the same cycle.
REQ-025 Latency, with the accept edge as T0: single-cycle op done at T0+1; MULU/DIVU done at T0+WIDTH+1.
REQ-026 busy SHALL be 1 exactly while in RUN.
REQ-027 MULU: {result_hi, result} = unsigned 2*WIDTH-bit product.
REQ-028 DIVU: result = quotient, result_hi = remainder (unsigned).
REQ-029 DIVU with input2 = 0 SHALL skip RUN and complete at T0+1 with result = all ones and result_hi = input1.
REQ-030 result, result_hi and zero SHALL update only on completion and hold until the next completion.
REQ-031 zero SHALL reflect result only, never result_hi.
REQ-032 Back-to-back: start held high SHALL issue one operation per completion, with no lost or duplicated done.

Reset
REQ-033 With rst_n = 0 at a rising edge, the block SHALL enter IDLE with busy = 0, done = 0, result = 0, result_hi = 0, zero = 1.
REQ-034 Reset during RUN SHALL abort the operation with no done pulse; start SHALL be ignored while rst_n = 0.

Verification (WIDTH = 32)
REQ-035 ADD 6 + 3 -> done at T0+1, result = 9, zero = 0; SUB 10 - 10 -> result = 0, zero = 1.
REQ-036 SLL input2 = 4, shamt = 2 -> result = 16; SRA input2 = 0x8000_0000, shamt = 4 -> result = 0xF800_0000; SLT -1 < 1 -> result = 1.
REQ-037 MULU 0xFFFF_FFFF * 2 -> busy for 32 cycles, done at T0+33, result = 0xFFFF_FFFE, result_hi = 1.
REQ-038 DIVU 100 / 7 -> result = 14, result_hi = 2; a start pulse at T0+5 with ADD is ignored, and outputs are unchanged until done.
REQ-039 DIVU 55 / 0 -> done at T0+1, result = 0xFFFF_FFFF, result_hi = 55, busy never asserts.
REQ-040 rst_n = 0 at T0+10 of a MULU -> IDLE, outputs at reset values, no done; a following ADD 1 + 1 -> result = 2.
